// File: rtl/enc_dec_scheduler.sv
// Round-robin sequencer sharing one 8->3->8 encoder/decoder datapath among NREQ requesters.
// Optional mismatch counter built only when ENCDEC_ERRCNT_EN is defined.
module enc_dec_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      dp_in,
    input  logic [DW-1:0]      dp_out,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IW-1:0]      resp_id,
    output logic [DW-1:0]      resp_data,
    output logic               resp_match,
    output logic               busy,
    output logic [7:0]         err_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [DW-1:0]   dp_in_q, dp_in_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IW-1:0]   resp_id_q, resp_id_d;
    logic [DW-1:0]   resp_data_q, resp_data_d;
    logic            resp_match_q, resp_match_d;
    logic            busy_q, busy_d;

    logic            grant_vld;
    logic [IW-1:0]   grant_idx;
    logic [DW-1:0]   grant_data;
    logic [DW-1:0]   exp_val;
    logic            mismatch;

    // Search upward from ptr+1, wrapping modulo NREQ (NREQ need not be a power of two).
    always_comb begin
        int sum;
        logic [IW-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            sum = int'(ptr_q) + i;
            if (sum >= int'(NREQ)) begin
                sum = sum - int'(NREQ);
            end
            cand = IW'(sum);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (grant_idx == IW'(k)) begin
                grant_data = data[k*DW +: DW];
            end
        end
    end

    // Expected round trip keeps only the highest set bit; zero input decodes to zero.
    always_comb begin
        exp_val = '0;
        for (int i = 0; i < int'(DW); i++) begin
            if (dp_in_q[i]) begin
                exp_val    = '0;
                exp_val[i] = 1'b1;
            end
        end
    end

    assign mismatch = (dp_out != exp_val);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        ack_d        = '0;
        dp_in_d      = dp_in_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_match_d = resp_match_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d          = DRIVE;
                    ptr_d            = grant_idx;
                    ack_d[grant_idx] = 1'b1;
                    dp_in_d          = grant_data;
                    resp_id_d        = grant_idx;
                end
            end
            DRIVE: begin
                state_d      = RESP;
                resp_data_d  = dp_out;
                resp_match_d = !mismatch;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= IW'(NREQ - 1);
            ack_q        <= '0;
            dp_in_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_match_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ack_q        <= ack_d;
            dp_in_q      <= dp_in_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_match_q <= resp_match_d;
            busy_q       <= busy_d;
        end
    end

`ifdef ENCDEC_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else if (state_q == DRIVE && mismatch && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    assign ack        = ack_q;
    assign dp_in      = dp_in_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_match = resp_match_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_enc_dec_scheduler.sv
// Bench for enc_dec_scheduler: table-driven transactions, round-robin, backpressure, reset, saturation.
// Models the external encoder/decoder with injectable faults; expected responses go through a queue.
module tb_enc_dec_scheduler;

`ifdef ENCDEC_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_bus;
    logic [3:0]  ack;
    logic [7:0]  dp_in;
    logic [7:0]  dp_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [7:0]  resp_data;
    logic        resp_match;
    logic        busy;
    logic [7:0]  err_cnt;

    int fault;
    int n_checks;
    int n_fail;
    int cyc;
    int exp_err;

    typedef struct {
        logic [3:0] req;
        logic [7:0] din;
        int         fault;
        int         id;
        logic [7:0] exp_data;
        logic       exp_match;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       match;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    enc_dec_scheduler #(.NREQ(4), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data       (data_bus),
        .ack        (ack),
        .dp_in      (dp_in),
        .dp_out     (dp_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_match (resp_match),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External datapath: priority encoder to index+good, then decoder back to one-hot.
    function automatic logic [7:0] encdec(input logic [7:0] v);
        logic [2:0] idx;
        logic       good;
        idx  = 3'd0;
        good = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx  = i[2:0];
                good = 1'b1;
            end
        end
        return good ? (8'h01 << idx) : 8'h00;
    endfunction

    always_comb begin
        dp_out = encdec(dp_in);
        if (fault == 1 && dp_in == 8'h40) begin
            dp_out = 8'h01;
        end else if (fault == 2) begin
            dp_out = ~encdec(dp_in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compares a pending handshake against the scoreboard, then advances one clock.
    task automatic tick();
        exp_t e;
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got id %0d data %0h expected no response",
                         resp_id, resp_data);
            end else begin
                e = sb.pop_front();
                chk("resp_id", 32'(resp_id), 32'(e.id));
                chk("resp_data", 32'(resp_data), 32'(e.data));
                chk("resp_match", 32'(resp_match), 32'(e.match));
            end
        end
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic push_exp(input int id, input logic [7:0] d, input logic m);
        exp_t e;
        e.id    = id;
        e.data  = d;
        e.match = m;
        sb.push_back(e);
        if (!m && ERRCNT_EN && exp_err < 255) begin
            exp_err++;
        end
    endtask

    // One full transaction with RespReady high; starts and ends in IDLE.
    task automatic run_vec(input vec_t v);
        req                   = v.req;
        data_bus              = '0;
        data_bus[v.id*8 +: 8] = v.din;
        fault                 = v.fault;
        push_exp(v.id, v.exp_data, v.exp_match);
        tick();
        chk("ack", 32'(ack), 32'(v.req));
        chk("dp_in", 32'(dp_in), 32'(v.din));
        chk("busy_drive", 32'(busy), 32'd1);
        chk("valid_drive", 32'(resp_valid), 32'd0);
        req = '0;
        tick();
        chk("valid_resp", 32'(resp_valid), 32'd1);
        chk("ack_resp", 32'(ack), 32'd0);
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        tick();
        chk("valid_idle", 32'(resp_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_dp_in"}, 32'(dp_in), 32'd0);
        chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_id"}, 32'(resp_id), 32'd0);
        chk({tag, "_data"}, 32'(resp_data), 32'd0);
        chk({tag, "_match"}, 32'(resp_match), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order[6];
        int last;
        bit found;
        vec_t v;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        exp_err  = 0;
        fault    = 0;
        rst_n    = 1'b0;
        req      = '0;
        data_bus = '0;
        resp_ready = 1'b1;
        order    = '{0, 1, 2, 3, 0, 1};

        vecs[0] = '{4'b0001, 8'h20, 0, 0, 8'h20, 1'b1};
        vecs[1] = '{4'b0001, 8'h00, 0, 0, 8'h00, 1'b1};
        vecs[2] = '{4'b0010, 8'hC5, 0, 1, 8'h80, 1'b1};
        vecs[3] = '{4'b0100, 8'h40, 1, 2, 8'h01, 1'b0};
        vecs[4] = '{4'b0010, 8'h40, 0, 1, 8'h40, 1'b1};
        vecs[5] = '{4'b1000, 8'hFF, 0, 3, 8'h80, 1'b1};
        vecs[6] = '{4'b1000, 8'h01, 0, 3, 8'h01, 1'b1};

        @(posedge clk);
        @(posedge clk);
        #2;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post_rst");

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end
        fault = 0;

        // Round robin with all four requesting; last table grant was requester 3.
        req = 4'hF;
        for (int k = 0; k < 4; k++) begin
            data_bus[k*8 +: 8] = 8'h03 << k;
        end
        last = 0;
        for (int n = 0; n < 6; n++) begin
            found = 1'b0;
            for (int w = 0; w < 10 && !found; w++) begin
                tick();
                if (ack != 4'b0000) begin
                    found = 1'b1;
                end
            end
            if (!found) begin
                n_checks++;
                n_fail++;
                $display("FAIL rr_timeout: got no ack expected ack for requester %0d", order[n]);
            end else begin
                chk("rr_ack", 32'(ack), 32'(4'b0001 << order[n]));
                if (n > 0) begin
                    chk("rr_spacing", 32'(cyc - last), 32'd3);
                end
                last = cyc;
                push_exp(order[n], 8'h02 << order[n], 1'b1);
                req[order[n]] = 1'b0;
                tick();
                req[order[n]] = 1'b1;
            end
        end
        req = '0;
        tick();
        chk("rr_idle", 32'(busy), 32'd0);

        // Backpressure: pointer is at 1, so 1110 grants requester 2 first.
        resp_ready          = 1'b0;
        data_bus[2*8 +: 8]  = 8'h5A;
        req                 = 4'b1110;
        push_exp(2, 8'h40, 1'b1);
        tick();
        chk("bp_ack", 32'(ack), 32'b0100);
        tick();
        chk("bp_valid", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_data", 32'(resp_data), 32'h40);
            chk("bp_hold_id", 32'(resp_id), 32'd2);
            chk("bp_hold_ack", 32'(ack), 32'd0);
            chk("bp_hold_busy", 32'(busy), 32'd1);
        end
        push_exp(3, 8'h10, 1'b1);
        resp_ready = 1'b1;
        tick();
        chk("bp_hs_valid", 32'(resp_valid), 32'd0);
        chk("bp_hs_ack", 32'(ack), 32'd0);
        tick();
        chk("bp_next_ack", 32'(ack), 32'b1000);
        req = '0;
        tick();
        tick();

        // Reset during DRIVE discards the transaction.
        data_bus           = '0;
        data_bus[2*8 +: 8] = 8'h40;
        req                = 4'b0100;
        tick();
        chk("rd_ack", 32'(ack), 32'b0100);
        chk("rd_busy", 32'(busy), 32'd1);
        req = '0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        exp_err = 0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rd_no_pending", 32'(sb.size()), 32'd0);
        v = '{4'b0100, 8'h33, 0, 2, 8'h20, 1'b1};
        run_vec(v);

        // Forced mismatches drive the counter to saturation.
        v = '{4'b0001, 8'h40, 2, 0, 8'hBF, 1'b0};
        for (int i = 0; i < 300; i++) begin
            run_vec(v);
        end
        chk("err_sat", 32'(err_cnt), ERRCNT_EN ? 32'd255 : 32'd0);
        fault = 0;

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enc_dec_scheduler.md
# enc_dec_scheduler

Sequencer and round-robin arbiter that shares a single combinational encoder/decoder datapath (8-bit value → 3-bit index + Good → 8-bit one-hot) among several requesters. It grants one requester at a time, drives the shared datapath input, captures the datapath result, checks it against the expected round-trip value, and returns a tagged response through a valid/ready handshake. It sits between requester logic and the encoder/decoder instance, which is instantiated beside it and wired through the Dp* ports.

## Interface
- NREQ, 4, number of requesters (2..8); ID width IW = clog2(NREQ)
- DW, 8, datapath width (fixed at 8 for the 8→3→8 datapath)
- Clk  in  1  rising-edge clock, single clock domain
- Rst_n  in  1  asynchronous, active-low reset
- Req  in  NREQ  per-requester request level
- Data  in  NREQ*DW  request payloads; requester k occupies bits [k*DW +: DW]
- Ack  out  NREQ  one-cycle grant/accept pulse, one-hot or zero
- DpIn  out  DW  registered drive to shared datapath input
- DpOut  in  DW  shared datapath output, combinational from DpIn
- RespValid  out  1  response available
- RespReady  in  1  consumer accepts response
- RespId  out  IW  index of the requester being served
- RespData  out  DW  captured DpOut
- RespMatch  out  1  RespData equals expected round-trip value
- Busy  out  1  high in any state other than IDLE
- ErrCnt  out  8  mismatch counter (see Configuration)

## Operation
- FSM states: IDLE, DRIVE, RESP.
- IDLE: if Req != 0, select the first set Req bit searching upward from Ptr+1, wrapping modulo NREQ. Load DpIn ← Data[k], RespId ← k, Ptr ← k; pulse Ack[k]; go to DRIVE. If Req == 0, stay in IDLE.
- DRIVE: DpIn is stable and the datapath settles. At the end of the cycle, capture RespData ← DpOut and RespMatch ← (DpOut == Exp); go to RESP.
- Exp = MSB-isolate(DpIn): only the highest set bit of DpIn is kept. Exp = 0 when DpIn = 0, because Good = 0 and the decoder outputs 0.
- RESP: RespValid = 1. RespId, RespData and RespMatch hold stable. On RespValid & RespReady, go to IDLE.
- Req is not sampled outside IDLE. A requester holds Req and Data until it sees Ack and deasserts Req the cycle after Ack. If Req is still high in the next IDLE, it is re-arbitrated as a new request.
- Req withdrawn before grant: no action. Only the arbiter updates Ptr.
- Reset values:
  - state = IDLE
  - Ptr = NREQ-1, so requester 0 has first priority
  - Ack = 0, DpIn = 0, RespValid = 0, RespId = 0, RespData = 0, RespMatch = 0, Busy = 0, ErrCnt = 0
- Reset asserted mid-transaction: the transaction is discarded with no response and no Ack replay. Outputs return to reset values asynchronously.

## Timing
- Req sampled high at edge N (state IDLE): Ack[k] is high for the cycle after edge N; DpIn is valid from edge N.
- Capture at edge N+1; RespValid is high from edge N+1.
- With RespReady held high: handshake at edge N+2, back in IDLE after edge N+2, next grant at edge N+3. Minimum issue interval is 3 cycles.
- RespReady low: remain in RESP indefinitely, with no new grants and Ack held at 0.
- RespReady high while RespValid is low: ignored.
- All outputs are registered. DpOut is the only combinational path into the block and must settle within one cycle of DpIn.

## Configuration
- ENCDEC_ERRCNT_EN defined:
  - ErrCnt increments by 1 at each DRIVE→RESP capture where the computed match is 0.
  - ErrCnt saturates at 255 and clears only on reset.
- ENCDEC_ERRCNT_EN undefined:
  - no counter logic is built and ErrCnt is tied to 0.
  - all other behaviour is identical.

## Test plan
- Single requester, NREQ=4, Req=0001, Data0=8'h20, correct datapath, RespReady=1:
  - Ack=0001 one cycle after the Req edge.
  - RespValid two cycles after the Req edge, with RespId=0, RespData=8'h20, RespMatch=1.
- All four requesting continuously, each dropping and re-raising Req after its Ack: grant order is 0,1,2,3,0,1; Ack pulses are spaced 3 cycles apart.
- Data=8'h00:
  - RespData=8'h00 and RespMatch=1.
  - Data=8'hC5 gives RespData=8'h80 and RespMatch=1.
  - Datapath faulted to return 8'h01 for input 8'h40 gives RespMatch=0.
  - With ENCDEC_ERRCNT_EN defined, ErrCnt=1.
- Backpressure:
  - With RespReady=0 for 10 cycles while Req=1110, RespValid and RespData stay stable, Ack stays 0, and Busy=1.
  - On RespReady=1, the handshake completes and the next grant follows 1 cycle later.
- Rst_n pulsed low during DRIVE: all outputs are reset immediately and no response is issued. After release with Req=0100, requester 2 is served with RespId=2.
- With ENCDEC_ERRCNT_EN defined, 300 forced mismatches: ErrCnt saturates at 255 and stays there.
